// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing two register-file read channels among NREQ requesters.
// One-cycle read latency, with writeback forwarding and x0 handling on the response.
module regfile_read_arbiter #(
  parameter  int XLEN = 32,
  parameter  int XCNT = 32,
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(XCNT),
  localparam int PW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*IW-1:0]   req_idx_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [NREQ*XLEN-1:0] rsp_val_o,
  output logic [IW-1:0]        rch1_idx_o,
  output logic [IW-1:0]        rch2_idx_o,
  output logic                 rch1_resp_o,
  output logic                 rch2_resp_o,
  input  logic [XLEN-1:0]      rch1_val_i,
  input  logic [XLEN-1:0]      rch2_val_i,
  input  logic                 wb_valid_i,
  input  logic [IW-1:0]        wb_idx_i,
  input  logic [XLEN-1:0]      wb_val_i
);

  logic [PW-1:0]                ptr_q, ptr_d;
  logic [1:0]                   g_vld;
  logic [1:0][PW-1:0]           g_id;
  logic [1:0][IW-1:0]           g_idx;
  logic [1:0]                   s_vld_q;
  logic [1:0][PW-1:0]           s_id_q;
  logic [1:0][IW-1:0]           s_idx_q;
  logic                         wbq_vld_q;
  logic [IW-1:0]                wbq_idx_q;
  logic [XLEN-1:0]              wbq_val_q;
  logic [1:0][XLEN-1:0]         rch_val;
  logic [1:0][XLEN-1:0]         fwd;
  logic [NREQ-1:0][XLEN-1:0]    rsp_data, rsp_hold_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] id);
    return (id == PW'(NREQ-1)) ? '0 : id + PW'(1);
  endfunction

  // Ascending scan from ptr: first valid takes channel 1, second takes channel 2.
  always_comb begin
    int j;
    j     = 0;
    g_vld = '0;
    g_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (req_valid_i[j]) begin
        if (!g_vld[0]) begin
          g_vld[0] = 1'b1;
          g_id[0]  = PW'(j);
        end else if (!g_vld[1]) begin
          g_vld[1] = 1'b1;
          g_id[1]  = PW'(j);
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    for (int c = 0; c < 2; c++) begin
      g_idx[c] = req_idx_i[g_id[c]*IW +: IW];
      if (g_vld[c]) req_ready_o[g_id[c]] = 1'b1;
    end
    ptr_d = g_vld[1] ? nxt(g_id[1]) : g_vld[0] ? nxt(g_id[0]) : ptr_q;
  end

  // Channels stay idle while reset is held even though ready remains combinational.
  assign rch1_resp_o = ~(g_vld[0] & rst_n);
  assign rch2_resp_o = ~(g_vld[1] & rst_n);
  assign rch1_idx_o  = (g_vld[0] & rst_n) ? g_idx[0] : '0;
  assign rch2_idx_o  = (g_vld[1] & rst_n) ? g_idx[1] : '0;
  assign rch_val     = {rch2_val_i, rch1_val_i};

  // Newest writeback wins; x0 always reads zero and is never forwarded.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      fwd[c] = rch_val[c];
      if (s_idx_q[c] == '0)                                fwd[c] = '0;
      else if (wb_valid_i && wb_idx_i == s_idx_q[c])       fwd[c] = wb_val_i;
      else if (wbq_vld_q && wbq_idx_q == s_idx_q[c])       fwd[c] = wbq_val_q;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_data    = rsp_hold_q;
    for (int c = 0; c < 2; c++) begin
      if (s_vld_q[c]) begin
        rsp_valid_o[s_id_q[c]] = 1'b1;
        rsp_data[s_id_q[c]]    = fwd[c];
      end
    end
  end

  assign rsp_val_o = rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      s_vld_q    <= '0;
      s_id_q     <= '0;
      s_idx_q    <= '0;
      wbq_vld_q  <= 1'b0;
      wbq_idx_q  <= '0;
      wbq_val_q  <= '0;
      rsp_hold_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s_vld_q    <= g_vld;
      for (int c = 0; c < 2; c++) begin
        s_id_q[c]  <= g_vld[c] ? g_id[c]  : '0;
        s_idx_q[c] <= g_vld[c] ? g_idx[c] : '0;
      end
      wbq_vld_q  <= wb_valid_i && (wb_idx_i != '0);
      wbq_idx_q  <= wb_idx_i;
      wbq_val_q  <= wb_val_i;
      rsp_hold_q <= rsp_data;
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: round-robin table plus forwarding/reset sequences.
module tb_regfile_read_arbiter;
  localparam int XLEN = 32;
  localparam int XCNT = 32;
  localparam int NREQ = 4;
  localparam int IW   = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IW-1:0]   req_idx;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ*XLEN-1:0] rsp_val;
  logic [IW-1:0]        rch1_idx, rch2_idx;
  logic                 rch1_resp, rch2_resp;
  logic [XLEN-1:0]      rch1_val, rch2_val;
  logic                 wb_valid;
  logic [IW-1:0]        wb_idx;
  logic [XLEN-1:0]      wb_val;

  logic [XLEN-1:0]      rf [XCNT];
  logic [XLEN-1:0]      exp_hold [NREQ];
  int                   tests = 0;
  int                   fails = 0;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] ready;
    logic       c1_on;
    logic [4:0] c1_idx;
    logic       c2_on;
    logic [4:0] c2_idx;
    logic [3:0] rspv;
  } vec_t;
  vec_t tbl [11];

  regfile_read_arbiter #(.XLEN(XLEN), .XCNT(XCNT), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_idx_i(req_idx), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_val_o(rsp_val),
    .rch1_idx_o(rch1_idx), .rch2_idx_o(rch2_idx),
    .rch1_resp_o(rch1_resp), .rch2_resp_o(rch2_resp),
    .rch1_val_i(rch1_val), .rch2_val_i(rch2_val),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_val_i(wb_val)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read, data valid the cycle after issue.
  always @(posedge clk) begin
    rch1_val <= rf[rch1_idx];
    rch2_val <= rf[rch2_idx];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slice(input int i);
    return rsp_val[i*XLEN +: XLEN];
  endfunction

  initial begin
    for (int i = 0; i < XCNT; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'hFFFF_FFFF;
    rf[5] = 32'h11;
    rf[7] = 32'hDEAD_BEEF;
    for (int i = 0; i < NREQ; i++) exp_hold[i] = '0;

    tbl[0]  = '{4'b1111, 4'b0011, 1'b1, 5'd1, 1'b1, 5'd2, 4'b0000};
    tbl[1]  = '{4'b1111, 4'b1100, 1'b1, 5'd3, 1'b1, 5'd4, 4'b0011};
    tbl[2]  = '{4'b1111, 4'b0011, 1'b1, 5'd1, 1'b1, 5'd2, 4'b1100};
    tbl[3]  = '{4'b1111, 4'b1100, 1'b1, 5'd3, 1'b1, 5'd4, 4'b0011};
    tbl[4]  = '{4'b1000, 4'b1000, 1'b1, 5'd4, 1'b0, 5'd0, 4'b1100};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 5'd0, 1'b0, 5'd0, 4'b1000};
    tbl[6]  = '{4'b0110, 4'b0110, 1'b1, 5'd2, 1'b1, 5'd3, 4'b0000};
    tbl[7]  = '{4'b1011, 4'b1001, 1'b1, 5'd4, 1'b1, 5'd1, 4'b0110};
    tbl[8]  = '{4'b0101, 4'b0101, 1'b1, 5'd3, 1'b1, 5'd1, 4'b1001};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0101};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0000};

    // Reset with requests pending.
    rst_n     = 1'b0;
    req_valid = 4'b0011;
    req_idx   = {5'd4, 5'd3, 5'd2, 5'd1};
    wb_valid  = 1'b0;
    wb_idx    = '0;
    wb_val    = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'b0011);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_val_lo", rsp_val[63:0] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
    chk("rst_rsp_val_hi", rsp_val[127:64] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
    chk("rst_rch1_resp", 32'(rch1_resp), 32'h1);
    chk("rst_rch2_resp", 32'(rch2_resp), 32'h1);
    chk("rst_rch1_idx", 32'(rch1_idx), 32'h0);
    chk("rst_rch2_idx", 32'(rch2_idx), 32'h0);

    // Round-robin table; requester i always reads x(i+1).
    for (int r = 0; r < 11; r++) begin
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = tbl[r].rv;
      #1;
      chk($sformatf("r%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
      chk($sformatf("r%0d_rch1_resp", r), 32'(rch1_resp), 32'(!tbl[r].c1_on));
      chk($sformatf("r%0d_rch1_idx", r), 32'(rch1_idx), 32'(tbl[r].c1_idx));
      chk($sformatf("r%0d_rch2_resp", r), 32'(rch2_resp), 32'(!tbl[r].c2_on));
      chk($sformatf("r%0d_rch2_idx", r), 32'(rch2_idx), 32'(tbl[r].c2_idx));
      chk($sformatf("r%0d_rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].rspv));
      for (int i = 0; i < NREQ; i++) begin
        if (tbl[r].rspv[i]) exp_hold[i] = 32'h101 + i;
        chk($sformatf("r%0d_rsp_val%0d", r, i), slice(i), exp_hold[i]);
      end
    end

    // Single requester 3 reading x7; pointer must wrap to 0.
    @(negedge clk);
    req_valid = 4'b1000;
    req_idx   = {5'd7, 5'd3, 5'd2, 5'd1};
    #1;
    chk("single_ready", 32'(req_ready), 32'b1000);
    chk("single_rch1_idx", 32'(rch1_idx), 32'd7);
    chk("single_rch1_resp", 32'(rch1_resp), 32'h0);
    chk("single_rch2_resp", 32'(rch2_resp), 32'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'b1000);
    chk("single_rsp_val", slice(3), 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid = 4'b1111;
    req_idx   = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    chk("single_ptr_wrap", 32'(req_ready), 32'b0011);

    // Forwarding: plain read, issue-cycle WB, response-cycle WB, x0.
    @(negedge clk);
    req_valid = 4'b0001;
    req_idx   = {5'd4, 5'd3, 5'd2, 5'd5};
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("fwd_none", slice(0), 32'h11);

    @(negedge clk);
    req_valid = 4'b0001;
    wb_valid = 1'b1; wb_idx = 5'd5; wb_val = 32'h22;
    @(negedge clk);
    req_valid = 4'b0000;
    wb_valid = 1'b0;
    #1;
    chk("fwd_issue_vld", 32'(rsp_valid), 32'b0001);
    chk("fwd_issue", slice(0), 32'h22);

    @(negedge clk);
    req_valid = 4'b0001;
    wb_valid = 1'b1; wb_idx = 5'd5; wb_val = 32'h22;
    @(negedge clk);
    req_valid = 4'b0000;
    wb_val = 32'h33;
    #1;
    chk("fwd_resp", slice(0), 32'h33);

    @(negedge clk);
    req_valid = 4'b0001;
    req_idx   = {5'd4, 5'd3, 5'd2, 5'd0};
    wb_valid = 1'b1; wb_idx = 5'd0; wb_val = 32'h55;
    @(negedge clk);
    req_valid = 4'b0000;
    wb_val = 32'h66;
    #1;
    chk("x0_rsp_valid", 32'(rsp_valid), 32'b0001);
    chk("x0_val", slice(0), 32'h0);
    wb_valid = 1'b0;

    // Mid-operation reset drops the in-flight pair.
    @(negedge clk);
    req_valid = 4'b0011;
    req_idx   = {5'd4, 5'd3, 5'd2, 5'd1};
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("midrst_no_pulse", 32'(rsp_valid), 32'h0);
    chk("midrst_ptr0", 32'(req_ready), 32'b0011);
    @(negedge clk);
    req_valid = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
